// File: rtl/pcs_pkg.sv
// Shared PCS definitions used by both the receive and transmit sides:
// 8b/10b control-code values, GMII substitution bytes and the receive
// ordered-set FSM state encoding.
package pcs_pkg;

  localparam logic [7:0] PCS_CODE_I = 8'hBC;  // idle
  localparam logic [7:0] PCS_CODE_S = 8'hFB;  // start of packet
  localparam logic [7:0] PCS_CODE_T = 8'hFD;  // end of packet
  localparam logic [7:0] PCS_CODE_R = 8'hF7;  // carrier extend
  localparam logic [7:0] PCS_CODE_E = 8'hFE;  // error propagation

  localparam logic [7:0] PCS_PREAMBLE      = 8'h55;  // replaces S on rxd
  localparam logic [7:0] PCS_FALSE_CARRIER = 8'h0E;  // rxd on a false carrier

  typedef enum logic [2:0] {
    ST_LINK_FAILED = 3'd0,
    ST_WAIT_IDLE   = 3'd1,
    ST_IDLE        = 3'd2,
    ST_RECEIVE     = 3'd3,
    ST_EOP         = 3'd4
  } pcs_rx_state_e;

  // True when the code group is the given control character.
  function automatic logic is_ctrl(input logic is_k, input logic [7:0] code,
                                   input logic [7:0] ctrl);
    return is_k && (code == ctrl);
  endfunction

endpackage

// File: rtl/pcs_sat_counter.sv
// 16-bit event counter that saturates at all-ones.
// Ports: clk, rst (async, active-high), inc (count one event),
//        clr (synchronous clear, wins over inc), count (current value).
module pcs_sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 16'h0000;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pcs_receive_ordered_set.sv
// PCS receive ordered-set decoder: turns aligned code groups into GMII-style
// rxd/rx_dv/rx_er, detects frame boundaries and keeps frame statistics.
// Ports:
//   clk, rst            clock and async active-high reset
//   rx_code, rx_is_k    received code group and its control flag
//   rx_code_valid       qualifies rx_code; invalid cycles hold all state
//   sync_status         code-group alignment lock
//   rxd, rx_dv, rx_er   registered receive byte / valid / error
//   rx_idle             FSM is in IDLE
//   frame_done          one-cycle pulse on a T,R frame end
//   frame_len           data-byte count of the last completed frame
//   pkt_count           completed frames (saturating)
//   err_count           error events (saturating)
//   dbg_state           current FSM state
module pcs_receive_ordered_set
  import pcs_pkg::*;
#(
  parameter int MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_code,
  input  logic        rx_is_k,
  input  logic        rx_code_valid,
  input  logic        sync_status,
  output logic [7:0]  rxd,
  output logic        rx_dv,
  output logic        rx_er,
  output logic        rx_idle,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count,
  output logic [2:0]  dbg_state
);

  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);

  pcs_rx_state_e state_q, state_d;
  logic [7:0]    rxd_q, rxd_d;
  logic          rx_dv_q, rx_dv_d;
  logic          rx_er_q, rx_er_d;
  logic          frame_done_q, frame_done_d;
  logic [10:0]   frame_len_q, frame_len_d;
  logic [10:0]   byte_cnt_q, byte_cnt_d;
  logic          err_inc;
  logic          pkt_inc;

  always_comb begin
    state_d      = state_q;
    rxd_d        = rxd_q;
    rx_dv_d      = 1'b0;
    rx_er_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    byte_cnt_d   = byte_cnt_q;
    err_inc      = 1'b0;
    pkt_inc      = 1'b0;

    if (rx_code_valid) begin
      rxd_d = 8'h00;
      if (!sync_status) begin
        // Losing lock mid-frame is reported once as a receive error.
        state_d = ST_LINK_FAILED;
        if (state_q == ST_RECEIVE) begin
          rx_er_d = 1'b1;
          err_inc = 1'b1;
        end
      end else begin
        unique case (state_q)
          ST_LINK_FAILED: state_d = ST_WAIT_IDLE;
          ST_WAIT_IDLE: begin
            if (is_ctrl(rx_is_k, rx_code, PCS_CODE_I)) state_d = ST_IDLE;
          end
          ST_IDLE: begin
            if (is_ctrl(rx_is_k, rx_code, PCS_CODE_I)) begin
              state_d = ST_IDLE;
            end else if (is_ctrl(rx_is_k, rx_code, PCS_CODE_S)) begin
              state_d    = ST_RECEIVE;
              rxd_d      = PCS_PREAMBLE;
              rx_dv_d    = 1'b1;
              byte_cnt_d = 11'd0;
            end else begin
              state_d = ST_WAIT_IDLE;
              rxd_d   = PCS_FALSE_CARRIER;
              rx_er_d = 1'b1;
              err_inc = 1'b1;
            end
          end
          ST_RECEIVE: begin
            if (!rx_is_k) begin
              rxd_d   = rx_code;
              rx_dv_d = 1'b1;
              if (byte_cnt_q == MAX_LEN_C) begin
                // Oversize frame: flag it and drop back to hunting for idle.
                rx_er_d = 1'b1;
                err_inc = 1'b1;
                state_d = ST_WAIT_IDLE;
              end else begin
                byte_cnt_d = byte_cnt_q + 11'd1;
              end
            end else if (rx_code == PCS_CODE_T) begin
              state_d = ST_EOP;
            end else if (rx_code == PCS_CODE_I) begin
              rx_er_d = 1'b1;
              err_inc = 1'b1;
              state_d = ST_IDLE;
            end else begin
              // E and any unexpected control code: error inside the frame.
              rxd_d   = rx_code;
              rx_dv_d = 1'b1;
              rx_er_d = 1'b1;
              err_inc = 1'b1;
            end
          end
          ST_EOP: begin
            if (is_ctrl(rx_is_k, rx_code, PCS_CODE_R)) begin
              frame_done_d = 1'b1;
              frame_len_d  = byte_cnt_q;
              pkt_inc      = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              err_inc = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end
          default: state_d = ST_LINK_FAILED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LINK_FAILED;
      rxd_q        <= 8'h00;
      rx_dv_q      <= 1'b0;
      rx_er_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= 11'd0;
      byte_cnt_q   <= 11'd0;
    end else begin
      state_q      <= state_d;
      rxd_q        <= rxd_d;
      rx_dv_q      <= rx_dv_d;
      rx_er_q      <= rx_er_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  pcs_sat_counter u_pkt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pkt_inc),
    .clr   (1'b0),
    .count (pkt_count)
  );

  pcs_sat_counter u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (1'b0),
    .count (err_count)
  );

  assign rxd        = rxd_q;
  assign rx_dv      = rx_dv_q;
  assign rx_er      = rx_er_q;
  assign rx_idle    = (state_q == ST_IDLE);
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pcs_receive_ordered_set.sv
// Directed bench for pcs_receive_ordered_set, built with MAX_LEN=4 so the
// oversize path is reachable with short frames.
module tb_pcs_receive_ordered_set;
  import pcs_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_code;
  logic        rx_is_k;
  logic        rx_code_valid;
  logic        sync_status;
  logic [7:0]  rxd;
  logic        rx_dv;
  logic        rx_er;
  logic        rx_idle;
  logic        frame_done;
  logic [10:0] frame_len;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic [2:0]  dbg_state;

  int n_compared;
  int n_mismatched;

  pcs_receive_ordered_set #(.MAX_LEN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_code       (rx_code),
    .rx_is_k       (rx_is_k),
    .rx_code_valid (rx_code_valid),
    .sync_status   (sync_status),
    .rxd           (rxd),
    .rx_dv         (rx_dv),
    .rx_er         (rx_er),
    .rx_idle       (rx_idle),
    .frame_done    (frame_done),
    .frame_len     (frame_len),
    .pkt_count     (pkt_count),
    .err_count     (err_count),
    .dbg_state     (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present one code group for one clock, then sample after the edge.
  task automatic send(input logic k, input logic [7:0] code);
    rx_is_k       = k;
    rx_code       = code;
    rx_code_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    rx_code_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rx_code = 8'h00;
    rx_is_k = 1'b0;
    rx_code_valid = 1'b0;
    sync_status = 1'b0;
    n_compared = 0;
    n_mismatched = 0;
    #1;
    check("rst_rxd", 32'(rxd), 32'h0);
    check("rst_dv", 32'(rx_dv), 32'h0);
    check("rst_idle", 32'(rx_idle), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_LINK_FAILED));
    check("rst_cnts", {pkt_count, err_count}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sync_status = 1'b1;

    // Good frame: I,I,S,11,22,T,R,I
    send(1, PCS_CODE_I);
    check("g_wait_idle", 32'(dbg_state), 32'(ST_WAIT_IDLE));
    send(1, PCS_CODE_I);
    check("g_idle", 32'(rx_idle), 32'h1);
    send(1, PCS_CODE_S);
    check("g_pre", {23'h0, rx_dv, rxd}, {23'h0, 1'b1, 8'h55});
    send(0, 8'h11);
    check("g_d11", {23'h0, rx_dv, rxd}, {23'h0, 1'b1, 8'h11});
    send(0, 8'h22);
    check("g_d22", {22'h0, rx_er, rx_dv, rxd}, {22'h0, 1'b0, 1'b1, 8'h22});
    send(1, PCS_CODE_T);
    check("g_t_dv", 32'(rx_dv), 32'h0);
    send(1, PCS_CODE_R);
    check("g_done", 32'(frame_done), 32'h1);
    check("g_len", 32'(frame_len), 32'd2);
    check("g_pkt", 32'(pkt_count), 32'd1);
    send(1, PCS_CODE_I);
    check("g_done_pulse", 32'(frame_done), 32'h0);
    check("g_err0", 32'(err_count), 32'd0);
    check("g_idle2", 32'(rx_idle), 32'h1);

    // False carrier in IDLE
    send(0, 8'h33);
    check("fc_er", {22'h0, rx_er, rx_dv, rxd}, {22'h0, 1'b1, 1'b0, 8'h0E});
    check("fc_err", 32'(err_count), 32'd1);
    send(0, 8'h44);
    check("fc_stay", {30'h0, rx_idle, rx_er}, 32'h0);
    send(1, PCS_CODE_I);
    check("fc_back", 32'(rx_idle), 32'h1);

    // Error propagation: S,AA,E,BB,T,R
    send(1, PCS_CODE_S);
    check("e_pre", {30'h0, rx_er, rx_dv}, 32'h1);
    send(0, 8'hAA);
    check("e_aa", {22'h0, rx_er, rx_dv, rxd}, {22'h0, 1'b0, 1'b1, 8'hAA});
    send(1, PCS_CODE_E);
    check("e_e", {30'h0, rx_er, rx_dv}, 32'h3);
    check("e_err", 32'(err_count), 32'd2);
    send(0, 8'hBB);
    check("e_bb", {22'h0, rx_er, rx_dv, rxd}, {22'h0, 1'b0, 1'b1, 8'hBB});
    send(1, PCS_CODE_T);
    send(1, PCS_CODE_R);
    check("e_pkt", 32'(pkt_count), 32'd2);
    check("e_len", 32'(frame_len), 32'd2);

    // Invalid cycle mid-frame, then sync loss
    send(1, PCS_CODE_S);
    send(0, 8'h01);
    idle_cycle();
    check("nv_hold", {22'h0, rx_er, rx_dv, rxd}, {22'h0, 1'b0, 1'b0, 8'h01});
    check("nv_state", 32'(dbg_state), 32'(ST_RECEIVE));
    sync_status = 1'b0;
    send(0, 8'h02);
    check("sl_er", {30'h0, rx_er, rx_dv}, 32'h2);
    check("sl_err", 32'(err_count), 32'd3);
    check("sl_state", 32'(dbg_state), 32'(ST_LINK_FAILED));
    sync_status = 1'b1;
    send(1, PCS_CODE_S);
    check("sl_after", {29'h0, rx_er, rx_dv, rx_idle}, 32'h0);
    send(1, PCS_CODE_S);
    check("sl_no_s", 32'(dbg_state), 32'(ST_WAIT_IDLE));
    send(1, PCS_CODE_I);
    send(1, PCS_CODE_S);
    check("sl_s_ok", {23'h0, rx_dv, rxd}, {23'h0, 1'b1, 8'h55});

    // Oversize: four bytes fit, the fifth does not
    for (int i = 0; i < 4; i++) begin
      send(0, 8'(i + 8'h60));
      check("ov_in", {22'h0, rx_er, rx_dv, rxd}, {22'h0, 1'b0, 1'b1, 8'(i + 8'h60)});
    end
    send(0, 8'h64);
    check("ov_er", 32'(rx_er), 32'h1);
    check("ov_err", 32'(err_count), 32'd4);
    check("ov_state", 32'(dbg_state), 32'(ST_WAIT_IDLE));
    send(1, PCS_CODE_I);

    // Bad end: T then not R
    send(1, PCS_CODE_S);
    send(0, 8'h01);
    send(1, PCS_CODE_T);
    send(1, PCS_CODE_I);
    check("eop_err", 32'(err_count), 32'd5);
    check("eop_state", 32'(dbg_state), 32'(ST_WAIT_IDLE));
    check("eop_len", 32'(frame_len), 32'd2);
    check("eop_pkt", 32'(pkt_count), 32'd2);
    send(1, PCS_CODE_I);

    // Early end with I
    send(1, PCS_CODE_S);
    send(0, 8'h01);
    send(1, PCS_CODE_I);
    check("ee_er", {29'h0, rx_er, rx_dv, rx_idle}, 32'h5);
    check("ee_err", 32'(err_count), 32'd6);

    // Unexpected control code inside a frame
    send(1, PCS_CODE_S);
    send(1, PCS_CODE_R);
    check("ok_er", {30'h0, rx_er, rx_dv}, 32'h3);
    check("ok_err", 32'(err_count), 32'd7);
    check("ok_state", 32'(dbg_state), 32'(ST_RECEIVE));

    // Drive err_count to saturation with a run of E codes
    for (int i = 7; i < 16'hFFFD; i++) send(1, PCS_CODE_E);
    check("sat_fffd", 32'(err_count), 32'hFFFD);
    send(1, PCS_CODE_E);
    check("sat_fffe", 32'(err_count), 32'hFFFE);
    send(1, PCS_CODE_E);
    check("sat_ffff", 32'(err_count), 32'hFFFF);
    send(1, PCS_CODE_E);
    check("sat_hold", 32'(err_count), 32'hFFFF);
    check("sat_er", 32'(rx_er), 32'h1);

    // Asynchronous reset mid-frame
    send(1, PCS_CODE_I);
    send(1, PCS_CODE_S);
    send(0, 8'h11);
    check("ar_pre", 32'(rx_dv), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_out", {14'h0, rx_er, rx_dv, rxd, rx_idle, frame_done, frame_len[5:0]}, 32'h0);
    check("ar_cnts", {pkt_count, err_count}, 32'h0);
    check("ar_len", 32'(frame_len), 32'h0);
    check("ar_state", 32'(dbg_state), 32'(ST_LINK_FAILED));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pcs_receive_ordered_set.md
PCS_RECEIVE_ORDERED_SET -- requirements
Module: pcs_receive_ordered_set

Interface
REQ-001 Parameter MAX_LEN, default 1522, SHALL be the largest accepted frame length in bytes, counting from the first data byte after S.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 rx_code  input  8  SHALL be the received code group.
REQ-005 rx_is_k  input  1  SHALL mark rx_code as a control character when 1 and as data when 0.
REQ-006 rx_code_valid  input  1  SHALL qualify rx_code; the block ignores cycles with 0 and holds all state.
REQ-007 sync_status  input  1  SHALL be 1 while the code-group alignment is locked.
REQ-008 rxd  output  8  SHALL be the receive data byte, registered.
REQ-009 rx_dv  output  1  SHALL be the receive-data-valid flag, registered.
REQ-010 rx_er  output  1  SHALL be the receive-error flag, registered.
REQ-011 rx_idle  output  1  SHALL be 1 while the FSM is in IDLE.
REQ-012 frame_done  output  1  SHALL pulse for one cycle when a frame ends with T followed by R.
REQ-013 frame_len  output  11  SHALL hold the data-byte count of the last completed frame.
REQ-014 pkt_count  output  16  SHALL count completed frames, saturating at 16'hFFFF.
REQ-015 err_count  output  16  SHALL count error events, saturating at 16'hFFFF.

Function
REQ-016 The control codes SHALL be I=8'hBC, S=8'hFB, T=8'hFD, R=8'hF7 and E=8'hFE, each valid only with rx_is_k=1.
REQ-017 Outputs SHALL update on the clk edge that accepts a valid code, giving one cycle of latency; rx_dv, rx_er and frame_done SHALL be 0 on cycles where rx_code_valid=0.
REQ-018 The FSM states SHALL be LINK_FAILED, WAIT_IDLE, IDLE, RECEIVE and EOP.
REQ-019 sync_status=0 SHALL force LINK_FAILED from any state, with priority over every other transition.
REQ-020 If sync_status drops while the FSM is in RECEIVE, rx_er SHALL assert for that one cycle and err_count SHALL increment.
REQ-021 LINK_FAILED SHALL go to WAIT_IDLE on the first valid code with sync_status=1; rx_dv=0 and rx_er=0 in LINK_FAILED.
REQ-022 WAIT_IDLE SHALL go to IDLE on I and stay in WAIT_IDLE on any other code.
REQ-023 In IDLE, I SHALL keep the FSM in IDLE.
REQ-024 In IDLE, S SHALL go to RECEIVE, drive rxd=8'h55 with rx_dv=1, and clear the byte counter.
REQ-025 In IDLE, any other code (false carrier) SHALL drive rx_er=1 and rxd=8'h0E with rx_dv=0, increment err_count, and go to WAIT_IDLE.
REQ-026 In RECEIVE, a data code SHALL drive rxd=rx_code with rx_dv=1 and increment the byte counter.
REQ-027 In RECEIVE, E SHALL drive rx_dv=1, rx_er=1 and increment err_count, and SHALL stay in RECEIVE.
REQ-028 In RECEIVE, T SHALL drive rx_dv=0 and go to EOP.
REQ-029 In RECEIVE, I (early end) SHALL drive rx_er=1 and rx_dv=0, increment err_count, and go to IDLE.
REQ-030 In RECEIVE, any other control code SHALL drive rx_dv=1 and rx_er=1, increment err_count, and stay in RECEIVE.
REQ-031 In RECEIVE, a data byte that would make the count exceed MAX_LEN SHALL drive rx_er=1, increment err_count, and go to WAIT_IDLE.
REQ-032 In EOP, R SHALL pulse frame_done, load frame_len with the byte count, increment pkt_count, and go to IDLE.
REQ-033 In EOP, any code other than R SHALL increment err_count and go to WAIT_IDLE, leaving frame_len unchanged.
REQ-034 The byte counter SHALL be 11 bits and SHALL never wrap.
REQ-035 Both statistics counters SHALL hold at 16'hFFFF once saturated.
REQ-036 When an error event and a saturated err_count coincide, err_count SHALL stay at 16'hFFFF while rx_er still asserts.

Reset
REQ-037 rst=1 SHALL immediately put the FSM in LINK_FAILED and force rxd, rx_dv, rx_er, rx_idle, frame_done, frame_len, pkt_count, err_count and the byte counter to 0.
REQ-038 Reset asserted mid-frame SHALL drop rx_dv without asserting rx_er and without counting an error.

Structure
REQ-039 The control-code constants, the state encoding and the preamble (8'h55) and false-carrier (8'h0E) constants SHALL live in the shared PCS package that the transmit side also uses.
REQ-040 The two saturating 16-bit counters SHALL be instances of one sub-module, pcs_sat_counter, with inputs inc and clr and a 16-bit output.

Verification
REQ-041 rst, then sync=1, stream I,I,S,8'h11,8'h22,T,R,I -> rxd 55,11,22 with rx_dv=1; frame_done once; frame_len=2; pkt_count=1; err_count=0.
REQ-042 In IDLE send data byte 8'h33 -> rx_er=1 for one cycle, rxd=8'h0E, err_count=1; FSM returns to IDLE only after the next I.
REQ-043 S,8'hAA,E,8'hBB,T,R -> rx_er=1 on the E cycle only, with rx_dv=1 throughout; pkt_count increments; frame_len=2.
REQ-044 Drop sync_status during RECEIVE -> one-cycle rx_er=1, then rx_dv=0; the FSM needs sync=1 plus an I before it accepts S again.
REQ-045 With MAX_LEN=4, send S plus 5 data bytes -> rx_er on the 5th byte and entry to WAIT_IDLE; with err_count preset near 16'hFFFF, repeated errors hold it at 16'hFFFF.
REQ-046 Assert rst mid-frame -> all outputs 0 asynchronously, before the next clk edge.
